packed_insn_fetch: RTL and testbench

Second-generation instruction fetcher for one channel half of the processor. It sits between the task launch FIFO, the shared SRAM port, the instruction decoder and the instruction FIFO. Compared with the first-generation fetcher it adds:
- operand fetch and full-byte opcodes
- instruction FIFO backpressure
- PULL arbitration against the task FIFO
- jump, suspend and skip resume handling
- a parametrised channel and PC width

---
 rtl/packed_insn_fetch.sv | 275 +++++++++++++++++++++++++++
 tb/tb_packed_insn_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_insn_fetch.sv
// packed_insn_fetch: fetches packed nibble/byte opcodes and operands for one channel half.
// Define IFETCH_PC_CACHE_EN to resume a re-launched task at its last suspended PC.
module packed_insn_fetch #(
    parameter int CHAN_SEL_SIZE     = 3,
    parameter int THREAD_SEL_SIZE   = 2,
    parameter int PC_SIZE           = 12,
    parameter int OPCODE_SIZE       = 8,
    parameter int OPERAND_SIZE      = 8,
    parameter int DECODED_INSN_SIZE = 24,
    parameter logic [DECODED_INSN_SIZE-1:0] DI_REQUESTPC = 24'h178000,
    parameter logic [DECODED_INSN_SIZE-1:0] DI_SUSPEND   = 24'h170000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [CHAN_SEL_SIZE-1:0]                  next_task_channel,
    input  logic [THREAD_SEL_SIZE-1:0]                next_task_thread,
    input  logic [OPERAND_SIZE-1:0]                   next_task_operand,
    input  logic                                      next_task_ready,
    output logic                                      next_task_ack,
    output logic [OPCODE_SIZE-1:0]                    opcode,
    input  logic [DECODED_INSN_SIZE-1:0]              decoded_insn,
    input  logic                                      need_operand,
    input  logic                                      insn_noop,
    input  logic                                      insn_suspend,
    input  logic                                      insn_pull,
    input  logic                                      insn_jump,
    input  logic                                      insn_full_byte,
    output logic [DECODED_INSN_SIZE+OPERAND_SIZE-1:0] ififo_di,
    output logic                                      ififo_shift,
    input  logic                                      ififo_full,
    input  logic                                      jump_enable,
    input  logic [PC_SIZE-1:0]                        jump_target,
    input  logic                                      suspend,
    input  logic                                      jump_susp_skipped,
    output logic [CHAN_SEL_SIZE+PC_SIZE-1:0]          mem_addr,
    output logic                                      mem_rd_en,
    input  logic [OPCODE_SIZE-1:0]                    mem_d_in,
    input  logic                                      mem_ack,
    output logic [CHAN_SEL_SIZE-1:0]                  current_channel,
    output logic [THREAD_SEL_SIZE-1:0]                current_thread,
    output logic [PC_SIZE-1:0]                        current_pc,
    output logic [OPERAND_SIZE-1:0]                   current_task_operand,
    output logic                                      pull_decoded
);

    localparam int DI_W = DECODED_INSN_SIZE + OPERAND_SIZE;
    localparam int NIB  = OPCODE_SIZE / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_EXEC, S_FETCH_WORD, S_FETCH_OPND, S_ISSUE, S_SECOND
    } state_t;

    state_t                     state_q, state_d;
    logic [CHAN_SEL_SIZE-1:0]   chan_q, chan_d;
    logic [THREAD_SEL_SIZE-1:0] thread_q, thread_d;
    logic [PC_SIZE-1:0]         pc_q, pc_d;
    logic [OPERAND_SIZE-1:0]    top_q, top_d;
    logic [OPERAND_SIZE-1:0]    opnd_q, opnd_d;
    logic [OPCODE_SIZE-1:0]     opc_q, opc_d;
    logic [OPCODE_SIZE-1:0]     nib_q, nib_d;
    logic                       nib_v_q, nib_v_d;
    logic                       first_q, first_d;
    logic                       pull_q, pull_d;
    logic                       ack_q, ack_d;
    logic                       shift_q, shift_d;
    logic [DI_W-1:0]            di_q, di_d;
`ifdef IFETCH_PC_CACHE_EN
    logic [CHAN_SEL_SIZE-1:0]   lch_q, lch_d;
    logic [THREAD_SEL_SIZE-1:0] lthr_q, lthr_d;
    logic [PC_SIZE-1:0]         lpc_q, lpc_d;
    logic                       lv_q, lv_d;
`endif

    logic            launch, hit, push, adv, task_match;
    logic [DI_W-1:0] push_di;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        thread_d = thread_q;
        pc_d     = pc_q;
        top_d    = top_q;
        opnd_d   = opnd_q;
        opc_d    = opc_q;
        nib_d    = nib_q;
        nib_v_d  = nib_v_q;
        first_d  = first_q;
        pull_d   = pull_q;
        ack_d    = 1'b0;
        shift_d  = 1'b0;
        di_d     = di_q;
`ifdef IFETCH_PC_CACHE_EN
        lch_d    = lch_q;
        lthr_d   = lthr_q;
        lpc_d    = lpc_q;
        lv_d     = lv_q;
`endif
        launch   = 1'b0;
        hit      = 1'b0;
        push     = 1'b0;
        adv      = 1'b0;
        push_di  = '0;
        opcode   = opc_q;
        task_match = (next_task_channel == chan_q) &&
                     (next_task_thread == thread_q);

        unique case (state_q)
            S_IDLE: launch = next_task_ready;
            S_WAIT_EXEC: begin
                if (suspend) begin
                    state_d = S_IDLE;
                    launch  = next_task_ready;
`ifdef IFETCH_PC_CACHE_EN
                    lch_d  = chan_q;
                    lthr_d = thread_q;
                    lpc_d  = pc_q;
                    lv_d   = 1'b1;
`endif
                end else if (jump_enable) begin
                    pc_d    = jump_target;
                    nib_v_d = 1'b0;
                    state_d = S_FETCH_WORD;
                end else if (jump_susp_skipped) begin
                    state_d = nib_v_q ? S_SECOND : S_FETCH_WORD;
                end
            end
            S_FETCH_WORD: begin
                if (mem_ack) begin
                    opcode  = mem_d_in;
                    opc_d   = mem_d_in;
                    pc_d    = pc_q + PC_SIZE'(1);
                    nib_v_d = !insn_full_byte;
                    if (!insn_full_byte)
                        nib_d = {mem_d_in[NIB-1:0], {NIB{1'b0}}};
                    state_d = need_operand ? S_FETCH_OPND : S_ISSUE;
                end
            end
            S_FETCH_OPND: begin
                if (mem_ack) begin
                    opnd_d  = OPERAND_SIZE'(mem_d_in);
                    pc_d    = pc_q + PC_SIZE'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                push_di = {decoded_insn, need_operand ? opnd_q : {OPERAND_SIZE{1'b0}}};
                // first instruction after a launch may be a conditional to ignore
                if (first_q && insn_noop) begin
                    first_d = 1'b0;
                    state_d = nib_v_q ? S_SECOND : S_FETCH_WORD;
                end else if (!ififo_full) begin
                    first_d = 1'b0;
                    push    = 1'b1;
                    if (!insn_pull) begin
                        adv = 1'b1;
                    end else if (!pull_q) begin
                        pull_d = 1'b1;
                        adv    = 1'b1;
                    end else if (next_task_ready && task_match) begin
                        ack_d = 1'b1;
                        top_d = next_task_operand;
                        adv   = 1'b1;
                    end else begin
                        push_di = {DI_SUSPEND, {OPERAND_SIZE{1'b0}}};
                        state_d = S_WAIT_EXEC;
                    end
                end
                if (adv)
                    state_d = (insn_jump || insn_suspend) ? S_WAIT_EXEC :
                              nib_v_q ? S_SECOND : S_FETCH_WORD;
            end
            S_SECOND: begin
                opcode  = nib_q;
                nib_v_d = 1'b0;
                if (insn_noop) begin
                    state_d = S_FETCH_WORD;
                end else begin
                    opc_d   = nib_q;
                    state_d = need_operand ? S_FETCH_OPND : S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef IFETCH_PC_CACHE_EN
        hit = lv_d && (lch_d == next_task_channel) &&
              (lthr_d == next_task_thread);
`endif

        if (launch) begin
            chan_d   = next_task_channel;
            thread_d = next_task_thread;
            top_d    = next_task_operand;
            ack_d    = 1'b1;
            pull_d   = 1'b0;
            nib_v_d  = 1'b0;
            if (hit) begin
`ifdef IFETCH_PC_CACHE_EN
                pc_d = lpc_d;
`endif
                first_d = 1'b0;
                state_d = S_FETCH_WORD;
            end else begin
                push    = 1'b1;
                push_di = {DI_REQUESTPC, {OPERAND_SIZE{1'b0}}};
                first_d = 1'b1;
                state_d = S_WAIT_EXEC;
            end
        end

        if (push) begin
            shift_d = 1'b1;
            di_d    = push_di;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            chan_q   <= '0;
            thread_q <= '1;
            pc_q     <= '0;
            top_q    <= '0;
            opnd_q   <= '0;
            opc_q    <= '0;
            nib_q    <= '0;
            nib_v_q  <= 1'b0;
            first_q  <= 1'b0;
            pull_q   <= 1'b0;
            ack_q    <= 1'b0;
            shift_q  <= 1'b0;
            di_q     <= '0;
`ifdef IFETCH_PC_CACHE_EN
            lch_q    <= '0;
            lthr_q   <= '0;
            lpc_q    <= '0;
            lv_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            thread_q <= thread_d;
            pc_q     <= pc_d;
            top_q    <= top_d;
            opnd_q   <= opnd_d;
            opc_q    <= opc_d;
            nib_q    <= nib_d;
            nib_v_q  <= nib_v_d;
            first_q  <= first_d;
            pull_q   <= pull_d;
            ack_q    <= ack_d;
            shift_q  <= shift_d;
            di_q     <= di_d;
`ifdef IFETCH_PC_CACHE_EN
            lch_q    <= lch_d;
            lthr_q   <= lthr_d;
            lpc_q    <= lpc_d;
            lv_q     <= lv_d;
`endif
        end
    end

    assign next_task_ack        = ack_q;
    assign ififo_shift          = shift_q;
    assign ififo_di             = di_q;
    assign mem_addr             = {chan_q, pc_q};
    assign mem_rd_en            = (state_q == S_FETCH_WORD) ||
                                  (state_q == S_FETCH_OPND);
    assign current_channel      = chan_q;
    assign current_thread       = thread_q;
    assign current_pc           = pc_q;
    assign current_task_operand = top_q;
    assign pull_decoded         = pull_q;

endmodule

// File: tb/tb_packed_insn_fetch.sv
// Directed bench for packed_insn_fetch: toy decoder, SRAM responder, push/read logs.
// Honours IFETCH_PC_CACHE_EN when the design is built with it.
module tb_packed_insn_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  next_task_channel = '0;
    logic [1:0]  next_task_thread = '0;
    logic [7:0]  next_task_operand = '0;
    logic        next_task_ready = 1'b0;
    logic        next_task_ack;
    logic [7:0]  opcode;
    logic [23:0] decoded_insn;
    logic        need_operand, insn_noop, insn_suspend;
    logic        insn_pull, insn_jump, insn_full_byte;
    logic [31:0] ififo_di;
    logic        ififo_shift;
    logic        ififo_full = 1'b0;
    logic        jump_enable = 1'b0;
    logic [11:0] jump_target = '0;
    logic        suspend = 1'b0;
    logic        jump_susp_skipped = 1'b0;
    logic [14:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_d_in = '0;
    logic        mem_ack = 1'b0;
    logic [2:0]  current_channel;
    logic [1:0]  current_thread;
    logic [11:0] current_pc;
    logic [7:0]  current_task_operand;
    logic        pull_decoded;

    packed_insn_fetch dut (
        .clk(clk), .reset(reset),
        .next_task_channel(next_task_channel),
        .next_task_thread(next_task_thread),
        .next_task_operand(next_task_operand),
        .next_task_ready(next_task_ready),
        .next_task_ack(next_task_ack),
        .opcode(opcode), .decoded_insn(decoded_insn),
        .need_operand(need_operand), .insn_noop(insn_noop),
        .insn_suspend(insn_suspend), .insn_pull(insn_pull),
        .insn_jump(insn_jump), .insn_full_byte(insn_full_byte),
        .ififo_di(ififo_di), .ififo_shift(ififo_shift),
        .ififo_full(ififo_full),
        .jump_enable(jump_enable), .jump_target(jump_target),
        .suspend(suspend), .jump_susp_skipped(jump_susp_skipped),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_d_in(mem_d_in), .mem_ack(mem_ack),
        .current_channel(current_channel),
        .current_thread(current_thread),
        .current_pc(current_pc),
        .current_task_operand(current_task_operand),
        .pull_decoded(pull_decoded)
    );

    always #5 clk = ~clk;

    // toy decoder keyed on the upper nibble
    always_comb begin
        decoded_insn   = {16'hD000, opcode};
        insn_full_byte = opcode[7];
        insn_noop      = opcode[7:4] == 4'h0;
        need_operand   = opcode[7:4] == 4'h9;
        insn_jump      = opcode[7:4] == 4'hA;
        insn_suspend   = opcode[7:4] == 4'hB;
        insn_pull      = (opcode[7:4] == 4'h3) || (opcode[7:4] == 4'hC);
    end

    logic [7:0]  mem [0:32767];
    logic [31:0] pq[$];
    logic [14:0] rq[$];
    bit          mem_en = 1'b1;
    bit          late_ack = 1'b0;
    int          acks = 0;
    int          nvec = 0;
    int          nerr = 0;

    always @(negedge clk) begin
        if (mem_en && mem_rd_en && !mem_ack) begin
            mem_ack  = 1'b1;
            mem_d_in = mem[mem_addr];
            rq.push_back(mem_addr);
        end else begin
            mem_ack  = late_ack;
            mem_d_in = 8'h00;
        end
    end

    always @(negedge clk) begin
        if (ififo_shift) pq.push_back(ififo_di);
        if (next_task_ack) acks++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pget(input int k);
        if (k < pq.size()) return pq[k];
        return 'x;
    endfunction

    function automatic logic [31:0] rget(input int k);
        if (k < rq.size()) return {17'd0, rq[k]};
        return 'x;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_push(input int n);
        int c = 0;
        while (pq.size() < n && c < 60) begin
            tick();
            c++;
        end
        ticks(2);
        chk("push count", pq.size(), n);
    endtask

    task automatic do_jump(input logic [11:0] t);
        jump_target = t;
        jump_enable = 1'b1;
        tick();
        jump_enable = 1'b0;
    endtask

    task automatic set_head(input logic [2:0] c, input logic [1:0] t,
                            input logic [7:0] o, input logic r);
        next_task_channel = c;
        next_task_thread  = t;
        next_task_operand = o;
        next_task_ready   = r;
    endtask

    typedef struct {
        logic [11:0] tgt;
        logic [7:0]  b0, b1, b2;
        int          n;
        logic [31:0] e0, e1, e2;
        logic [11:0] pc;
        logic [14:0] a0, a1;
    } vec_t;

    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] t1, t2;
        int a0;
        vt[0] = '{12'h010, 8'h21, 8'hA0, 8'h80, 3, 32'hD0002100,
                  32'hD0001000, 32'hD000A000, 12'h012, 15'h5010, 15'h5011};
        vt[1] = '{12'h020, 8'h95, 8'h7F, 8'hA0, 2, 32'hD000957F,
                  32'hD000A000, 32'h0, 12'h023, 15'h5020, 15'h5021};
        vt[2] = '{12'h030, 8'h05, 8'hA0, 8'h80, 3, 32'hD0000500,
                  32'hD0005000, 32'hD000A000, 12'h032, 15'h5030, 15'h5031};
        vt[3] = '{12'h040, 8'h20, 8'hA0, 8'h80, 2, 32'hD0002000,
                  32'hD000A000, 32'h0, 12'h042, 15'h5040, 15'h5041};
        vt[4] = '{12'hFFF, 8'h88, 8'hA0, 8'h80, 2, 32'hD0008800,
                  32'hD000A000, 32'h0, 12'h001, 15'h5FFF, 15'h5000};
        for (int i = 0; i < 32768; i++) mem[i] = 8'h80;

        ticks(2);
        chk("rst ack", next_task_ack, 0);
        chk("rst shift", ififo_shift, 0);
        chk("rst rd_en", mem_rd_en, 0);
        chk("rst chan", current_channel, 0);
        chk("rst thread", current_thread, 3);
        chk("rst pc", current_pc, 0);
        chk("rst top", current_task_operand, 0);
        chk("rst pull", pull_decoded, 0);
        chk("rst di", ififo_di, 0);
        reset = 1'b1;
        tick();

        set_head(3'd5, 2'd1, 8'h3C, 1'b1);
        tick();
        chk("launch ack", next_task_ack, 1);
        next_task_ready = 1'b0;
        chk("launch rd_en", mem_rd_en, 0);
        chk("launch chan", current_channel, 5);
        chk("launch thread", current_thread, 1);
        chk("launch top", current_task_operand, 8'h3C);
        tick();
        chk("launch ack 1cyc", next_task_ack, 0);
        chk("launch push n", pq.size(), 1);
        chk("launch push", pget(0), 32'h17800000);

        foreach (vt[i]) begin
            t1 = vt[i].tgt + 12'd1;
            t2 = vt[i].tgt + 12'd2;
            mem[{3'd5, vt[i].tgt}] = vt[i].b0;
            mem[{3'd5, t1}] = vt[i].b1;
            mem[{3'd5, t2}] = vt[i].b2;
            mem[{3'd5, t2 + 12'd1}] = 8'hA0;
            pq.delete();
            rq.delete();
            do_jump(vt[i].tgt);
            wait_push(vt[i].n);
            chk($sformatf("v%0d push0", i), pget(0), vt[i].e0);
            chk($sformatf("v%0d push1", i), pget(1), vt[i].e1);
            if (vt[i].n > 2) chk($sformatf("v%0d push2", i), pget(2), vt[i].e2);
            chk($sformatf("v%0d pc", i), current_pc, vt[i].pc);
            chk($sformatf("v%0d addr0", i), rget(0), vt[i].a0);
            chk($sformatf("v%0d addr1", i), rget(1), vt[i].a1);
        end

        mem[15'h5050] = 8'h88;
        mem[15'h5051] = 8'hA0;
        pq.delete();
        ififo_full = 1'b1;
        do_jump(12'h050);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("full shift", ififo_shift, 0);
            chk("full di", ififo_di, 32'hD000A000);
        end
        ififo_full = 1'b0;
        wait_push(2);
        chk("full rel push0", pget(0), 32'hD0008800);
        chk("full rel push1", pget(1), 32'hD000A000);

        mem[15'h5060] = 8'hC0;
        mem[15'h5061] = 8'hC1;
        mem[15'h5062] = 8'hA0;
        set_head(3'd5, 2'd1, 8'h99, 1'b1);
        pq.delete();
        a0 = acks;
        do_jump(12'h060);
        wait_push(3);
        chk("pull1 push0", pget(0), 32'hD000C000);
        chk("pull2 push", pget(1), 32'hD000C100);
        chk("pull2 ack", acks - a0, 1);
        chk("pull2 top", current_task_operand, 8'h99);
        chk("pull flag", pull_decoded, 1);

        mem[15'h5070] = 8'hC2;
        set_head(3'd2, 2'd0, 8'h11, 1'b1);
        pq.delete();
        do_jump(12'h070);
        wait_push(1);
        chk("pull rej", pget(0), 32'h17000000);
        pq.delete();
        a0 = acks;
        suspend = 1'b1;
        tick();
        suspend = 1'b0;
        next_task_ready = 1'b0;
        ticks(2);
        chk("susp launch n", pq.size(), 1);
        chk("susp launch push", pget(0), 32'h17800000);
        chk("susp launch ack", acks - a0, 1);
        chk("susp launch chan", current_channel, 2);
        chk("susp launch thread", current_thread, 0);
        chk("susp launch top", current_task_operand, 8'h11);
        chk("susp launch pull", pull_decoded, 0);

        mem[15'h2080] = 8'h31;
        mem[15'h2081] = 8'h32;
        mem[15'h2082] = 8'hA0;
        set_head(3'd5, 2'd1, 8'h3C, 1'b1);
        pq.delete();
        do_jump(12'h080);
        wait_push(3);
        jump_susp_skipped = 1'b1;
        tick();
        jump_susp_skipped = 1'b0;
        wait_push(5);
        chk("skip push0", pget(0), 32'hD0003100);
        chk("skip push1", pget(1), 32'hD0001000);
        chk("skip push2", pget(2), 32'h17000000);
        chk("skip push3", pget(3), 32'hD0002000);
        chk("skip push4", pget(4), 32'hD000A000);
        chk("skip pc", current_pc, 12'h083);

        mem[15'h5090] = 8'h05;
        mem[15'h5091] = 8'hA0;
        mem[15'h5092] = 8'hA0;
        pq.delete();
        suspend = 1'b1;
        tick();
        suspend = 1'b0;
        next_task_ready = 1'b0;
        ticks(2);
        do_jump(12'h090);
        wait_push(3);
        chk("first drop push0", pget(0), 32'h17800000);
        chk("first drop push1", pget(1), 32'hD0005000);
        chk("first drop push2", pget(2), 32'hD000A000);
        chk("first drop pc", current_pc, 12'h092);

        pq.delete();
        jump_target = 12'h0F0;
        jump_enable = 1'b1;
        suspend = 1'b1;
        tick();
        jump_enable = 1'b0;
        suspend = 1'b0;
        ticks(3);
        chk("prio rd_en", mem_rd_en, 0);
        chk("prio pc", current_pc, 12'h092);
        chk("prio no push", pq.size(), 0);
        rq.delete();
        set_head(3'd5, 2'd1, 8'h3C, 1'b1);
        tick();
        next_task_ready = 1'b0;
        ticks(8);
        chk("relaunch n", pq.size(), 1);
`ifdef IFETCH_PC_CACHE_EN
        chk("cache push", pget(0), 32'hD000A000);
        chk("cache addr", rget(0), 15'h5092);
`else
        chk("relaunch push", pget(0), 32'h17800000);
        chk("relaunch no read", rq.size(), 0);
`endif

        mem_en = 1'b0;
        pq.delete();
        do_jump(12'h0A0);
        ticks(2);
        chk("midread rd_en", mem_rd_en, 1);
        reset = 1'b0;
        tick();
        chk("midread rst rd_en", mem_rd_en, 0);
        reset = 1'b1;
        late_ack = 1'b1;
        tick();
        late_ack = 1'b0;
        ticks(2);
        chk("late ack rd_en", mem_rd_en, 0);
        chk("late ack no push", pq.size(), 0);
        chk("late ack pc", current_pc, 0);
        chk("late ack thread", current_thread, 3);
        chk("late ack chan", current_channel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
